// File: rtl/wb_arbiter.sv
// Two-requester Wishbone arbiter with round-robin grant, one transaction per grant,
// and a watchdog that terminates a cycle the slave never acknowledges.
module wb_arbiter #(
   parameter int AW     = 15,
   parameter int DW     = 32,
   parameter int TOBITS = 8
) (
   input  logic          clk,
   input  logic          arst,
   input  logic [AW-1:0] m0_adr_i,
   input  logic [DW-1:0] m0_dat_i,
   input  logic          m0_we_i,
   input  logic          m0_stb_i,
   output logic [DW-1:0] m0_dat_o,
   output logic          m0_ack_o,
   input  logic [AW-1:0] m1_adr_i,
   input  logic [DW-1:0] m1_dat_i,
   input  logic          m1_we_i,
   input  logic          m1_stb_i,
   output logic [DW-1:0] m1_dat_o,
   output logic          m1_ack_o,
   output logic [AW-1:0] s_adr_o,
   output logic [DW-1:0] s_dat_o,
   output logic          s_we_o,
   output logic          s_stb_o,
   input  logic [DW-1:0] s_dat_i,
   input  logic          s_ack_i,
   output logic [1:0]    gnt_o,
   output logic          tmo_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY0 = 2'd1,
      BUSY1 = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic              last_q, last_d;
   logic [TOBITS-1:0] wdog_q, wdog_d;

   logic              sel;
   logic              curStb;
   logic              ackOut;
   logic [DW-1:0]     datOut;

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         wdog_q  <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         wdog_q  <= wdog_d;
      end
   end

   // Everything on the shared bus is zero while idle, so reset forces all outputs low.
   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      wdog_d   = wdog_q;
      sel      = (state_q == BUSY1);
      curStb   = 1'b0;
      ackOut   = 1'b0;
      datOut   = '0;
      s_adr_o  = '0;
      s_dat_o  = '0;
      s_we_o   = 1'b0;
      s_stb_o  = 1'b0;
      gnt_o    = 2'b00;
      tmo_o    = 1'b0;
      m0_ack_o = 1'b0;
      m1_ack_o = 1'b0;
      m0_dat_o = '0;
      m1_dat_o = '0;

      case (state_q)
         IDLE: begin
            if (m0_stb_i && (!m1_stb_i || last_q)) begin
               state_d = BUSY0;
               wdog_d  = '0;
            end else if (m1_stb_i) begin
               state_d = BUSY1;
               wdog_d  = '0;
            end
         end

         BUSY0, BUSY1: begin
            curStb  = sel ? m1_stb_i : m0_stb_i;
            s_adr_o = sel ? m1_adr_i : m0_adr_i;
            s_dat_o = sel ? m1_dat_i : m0_dat_i;
            s_we_o  = sel ? m1_we_i  : m0_we_i;
            s_stb_o = curStb;
            gnt_o   = sel ? 2'b10 : 2'b01;
            datOut  = s_dat_i;

            // A real ack wins over the watchdog when both land on the same cycle.
            if (!curStb) begin
               state_d = IDLE;
               last_d  = sel;
            end else if (s_ack_i) begin
               ackOut  = 1'b1;
               state_d = IDLE;
               last_d  = sel;
            end else if (&wdog_q) begin
               ackOut  = 1'b1;
               datOut  = '1;
               tmo_o   = 1'b1;
               state_d = IDLE;
               last_d  = sel;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end

            if (sel) begin
               m1_ack_o = ackOut;
               m1_dat_o = datOut;
            end else begin
               m0_ack_o = ackOut;
               m0_dat_o = datOut;
            end
         end

         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter: grants, round-robin order,
// watchdog boundary, abort with stray ack, and asynchronous reset.
module tb_wb_arbiter;

   localparam int AW = 15;
   localparam int DW = 32;

   logic          clk;
   logic          arst;
   logic [AW-1:0] m0_adr, m1_adr;
   logic [DW-1:0] m0_wdat, m1_wdat;
   logic          m0_we, m1_we, m0_stb, m1_stb;
   logic [DW-1:0] m0_dat_o, m1_dat_o;
   logic          m0_ack_o, m1_ack_o;
   logic [AW-1:0] s_adr_o;
   logic [DW-1:0] s_dat_o;
   logic          s_we_o, s_stb_o;
   logic [DW-1:0] s_dat_i;
   logic          s_ack_i;
   logic [1:0]    gnt_o;
   logic          tmo_o;

   int total = 0;
   int bad   = 0;

   wb_arbiter #(.AW(AW), .DW(DW), .TOBITS(4)) dut (
      .clk(clk), .arst(arst),
      .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_we_i(m0_we), .m0_stb_i(m0_stb),
      .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
      .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_we_i(m1_we), .m1_stb_i(m1_stb),
      .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_stb_o(s_stb_o),
      .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
      .gnt_o(gnt_o), .tmo_o(tmo_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   // Entered in an idle cycle with the requester's strobe already up; leaves in the following idle cycle.
   task automatic doTxn(input int port, input int waits, input logic [31:0] rdata, input string tag);
      logic [1:0] g;
      g = (port == 0) ? 2'b01 : 2'b10;
      tick();
      chk({tag, ".gnt"}, gnt_o, g);
      chk({tag, ".stb"}, s_stb_o, 1'b1);
      chk({tag, ".adr"}, s_adr_o, (port == 0) ? m0_adr : m1_adr);
      for (int i = 0; i < waits; i++) begin
         chk({tag, ".waitAck"}, {m0_ack_o, m1_ack_o}, 2'b00);
         chk({tag, ".waitTmo"}, tmo_o, 1'b0);
         tick();
      end
      s_ack_i = 1'b1;
      s_dat_i = rdata;
      settle();
      chk({tag, ".ack"}, {m0_ack_o, m1_ack_o}, (port == 0) ? 2'b10 : 2'b01);
      chk({tag, ".dat"}, (port == 0) ? m0_dat_o : m1_dat_o, rdata);
      chk({tag, ".otherDat"}, (port == 0) ? m1_dat_o : m0_dat_o, 32'h0);
      chk({tag, ".tmo"}, tmo_o, 1'b0);
      tick();
      s_ack_i = 1'b0;
      s_dat_i = '0;
      settle();
      chk({tag, ".idleGnt"}, gnt_o, 2'b00);
      chk({tag, ".idleAck"}, {m0_ack_o, m1_ack_o}, 2'b00);
   endtask

   initial begin
      arst = 1'b1;
      m0_adr = '0; m1_adr = '0; m0_wdat = '0; m1_wdat = '0;
      m0_we = 1'b0; m1_we = 1'b0; m0_stb = 1'b0; m1_stb = 1'b0;
      s_dat_i = '0; s_ack_i = 1'b0;

      // Reset state
      #2;
      chk("rst.gnt", gnt_o, 2'b00);
      chk("rst.stb", s_stb_o, 1'b0);
      chk("rst.tmo", tmo_o, 1'b0);
      chk("rst.acks", {m0_ack_o, m1_ack_o}, 2'b00);
      tick();
      arst = 1'b0;
      settle();

      // Both requesters strobing continuously: strict alternation starting with port 0
      $display("[TB] round robin");
      m0_adr = 15'h0100; m1_adr = 15'h0200;
      m0_stb = 1'b1; m1_stb = 1'b1;
      settle();
      chk("rr.idle", gnt_o, 2'b00);
      for (int k = 0; k < 4; k++) begin
         doTxn(0, k % 2, 32'h1000_0000 + k, "rr.p0");
         doTxn(1, 1 - (k % 2), 32'h2000_0000 + k, "rr.p1");
      end
      m0_stb = 1'b0; m1_stb = 1'b0;
      tick();

      // Single m0 read with three wait cycles
      $display("[TB] m0 read");
      m0_adr = 15'h0123; m0_we = 1'b0; m0_stb = 1'b1;
      settle();
      chk("rd.preGnt", gnt_o, 2'b00);
      chk("rd.preStb", s_stb_o, 1'b0);
      doTxn(0, 3, 32'h1234_5678, "rd");
      m0_stb = 1'b0;
      tick();

      // m1 write with m0 strobing in the middle
      $display("[TB] m1 write");
      m1_adr = 15'h7FFF; m1_wdat = 32'hA5A5_A5A5; m1_we = 1'b1; m1_stb = 1'b1;
      settle();
      tick();
      chk("wr.gnt", gnt_o, 2'b10);
      chk("wr.adr", s_adr_o, 15'h7FFF);
      chk("wr.we", s_we_o, 1'b1);
      chk("wr.dat", s_dat_o, 32'hA5A5_A5A5);
      m0_adr = 15'h0042; m0_stb = 1'b1;
      settle();
      chk("wr.m0Wait", m0_ack_o, 1'b0);
      chk("wr.adrHeld", s_adr_o, 15'h7FFF);
      tick();
      chk("wr.m0Wait2", m0_ack_o, 1'b0);
      s_ack_i = 1'b1; s_dat_i = 32'hDEAD_0000;
      settle();
      chk("wr.ack", {m0_ack_o, m1_ack_o}, 2'b01);
      chk("wr.m0Dat", m0_dat_o, 32'h0);
      m1_stb = 1'b0; m1_we = 1'b0;
      tick();
      s_ack_i = 1'b0; s_dat_i = '0;
      settle();
      chk("wr.idle", gnt_o, 2'b00);
      doTxn(0, 1, 32'h0000_0042, "wr.m0");
      m0_stb = 1'b0;
      tick();

      // Watchdog: no ack, terminates when the counter reaches 15
      $display("[TB] timeout");
      m0_adr = 15'h0555; m0_stb = 1'b1; s_dat_i = 32'h0BAD_F00D;
      settle();
      tick();
      for (int i = 0; i < 15; i++) begin
         chk("to.noTmo", tmo_o, 1'b0);
         chk("to.noAck", m0_ack_o, 1'b0);
         tick();
      end
      chk("to.tmo", tmo_o, 1'b1);
      chk("to.ack", m0_ack_o, 1'b1);
      chk("to.dat", m0_dat_o, 32'hFFFF_FFFF);
      chk("to.m1Ack", m1_ack_o, 1'b0);
      chk("to.gnt", gnt_o, 2'b01);
      m0_stb = 1'b0;
      tick();
      s_dat_i = '0;
      settle();
      chk("to.pulse", tmo_o, 1'b0);
      chk("to.idle", gnt_o, 2'b00);
      m0_adr = 15'h0666; m0_stb = 1'b1;
      settle();
      doTxn(0, 2, 32'h5555_AAAA, "to.next");
      // Ack on the watchdog's final cycle is a normal completion
      doTxn(0, 15, 32'h600D_DA7A, "to.edge");
      m0_stb = 1'b0;
      tick();

      // m1 aborts, stray acks are ignored, then m0 wins contention
      $display("[TB] abort");
      m1_adr = 15'h0300; m1_stb = 1'b1;
      settle();
      tick();
      chk("ab.gnt", gnt_o, 2'b10);
      tick();
      m1_stb = 1'b0; s_ack_i = 1'b1;
      settle();
      chk("ab.stb", s_stb_o, 1'b0);
      chk("ab.ack", {m0_ack_o, m1_ack_o}, 2'b00);
      tick();
      chk("ab.idle", gnt_o, 2'b00);
      chk("ab.strayAck", {m0_ack_o, m1_ack_o}, 2'b00);
      chk("ab.strayDat", m1_dat_o, 32'h0);
      tick();
      s_ack_i = 1'b0;
      m0_adr = 15'h0011; m1_adr = 15'h0022; m0_stb = 1'b1; m1_stb = 1'b1;
      settle();
      doTxn(0, 0, 32'h0000_0011, "ab.m0");
      m0_stb = 1'b0;
      doTxn(1, 0, 32'h0000_0022, "ab.m1");
      m1_stb = 1'b0;
      tick();

      // Asynchronous reset during BUSY1
      $display("[TB] reset mid-transaction");
      m1_adr = 15'h1111; m1_wdat = 32'hCAFE_F00D; m1_we = 1'b1; m1_stb = 1'b1;
      settle();
      tick();
      chk("ar.gnt", gnt_o, 2'b10);
      chk("ar.stb", s_stb_o, 1'b1);
      #2;
      arst = 1'b1;
      #1;
      chk("ar.stbDrop", s_stb_o, 1'b0);
      chk("ar.gntDrop", gnt_o, 2'b00);
      chk("ar.adr", s_adr_o, 15'h0);
      chk("ar.dat", s_dat_o, 32'h0);
      chk("ar.we", s_we_o, 1'b0);
      m0_adr = 15'h0033; m0_stb = 1'b1;
      tick();
      chk("ar.held", gnt_o, 2'b00);
      arst = 1'b0;
      m1_we = 1'b0;
      settle();
      doTxn(0, 1, 32'h0000_0033, "ar.m0");
      m0_stb = 1'b0;
      doTxn(1, 0, 32'h0000_1111, "ar.m1");
      m1_stb = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
